// File: rtl/bus_master_pkg.sv
// Shared definitions for the bus master and its timeout timer: FSM state
// encoding, default widths, and the Moore decode of the control outputs.
package bus_master_pkg;

    localparam int unsigned ADDR_W_DEF  = 16;
    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned TIMEOUT_DEF = 255;

    // Encodings are fixed because the arbiter decodes the same values.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    // Control outputs that depend only on the present state (and the
    // latched direction, which is constant for the whole transaction).
    typedef struct packed {
        logic cmd_ready;
        logic req;
        logic resp_valid;
        logic bus_re;
        logic bus_we;
    } ctrl_t;

    function automatic ctrl_t ctrl_of(input state_t st, input logic we);
        ctrl_t c;
        c = '0;
        case (st)
            IDLE: c.cmd_ready = 1'b1;
            REQ:  c.req       = 1'b1;
            XFER: begin
                c.req    = 1'b1;
                c.bus_re = ~we;
                c.bus_we = we;
            end
            DONE: c.resp_valid = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Bits needed to hold the values 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bus_timer.sv
// Saturating XFER-cycle counter. expired is high during the enabled cycle
// that brings the count up to TIMEOUT, so the owner can leave on that edge.
module bus_timer
    import bus_master_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned     CW    = cnt_width(TIMEOUT);
    localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0]   LAST  = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Count enabled cycles, clear on request, hold at LIMIT instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count >= LAST);

endmodule

// File: rtl/bus_master.sv
// Single-outstanding bus master: accepts a local read/write command, requests
// the shared bus, performs one access with a timeout, then reports completion.
module bus_master
    import bus_master_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              cmd_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              req,
    input  logic              gnt,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_re,
    output logic              bus_we,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready
);

    state_t            state;
    ctrl_t             ctrl_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              expired;

    bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != XFER),
        .enable  (state == XFER),
        .expired (expired)
    );

    // Control outputs are registered alongside the state: every transition
    // loads the decode of the state being entered, so they stay pure Moore.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ctrl_q     <= ctrl_of(IDLE, 1'b0);
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        we_q    <= cmd_we;
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        state   <= REQ;
                        ctrl_q  <= ctrl_of(REQ, cmd_we);
                    end
                end
                REQ: begin
                    if (gnt) begin
                        state     <= XFER;
                        ctrl_q    <= ctrl_of(XFER, we_q);
                        bus_addr  <= addr_q;
                        bus_wdata <= we_q ? wdata_q : '0;
                    end
                end
                XFER: begin
                    if (!gnt || bus_ready || expired) begin
                        state     <= DONE;
                        ctrl_q    <= ctrl_of(DONE, we_q);
                        bus_addr  <= '0;
                        bus_wdata <= '0;
                        // Grant loss wins over a same-cycle bus_ready.
                        if (!gnt) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (bus_ready) begin
                            resp_err   <= 1'b0;
                            resp_rdata <= we_q ? '0 : bus_rdata;
                        end else begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    ctrl_q <= ctrl_of(IDLE, we_q);
                end
                default: begin
                    state  <= IDLE;
                    ctrl_q <= ctrl_of(IDLE, 1'b0);
                end
            endcase
        end
    end

    assign cmd_ready  = ctrl_q.cmd_ready;
    assign req        = ctrl_q.req;
    assign resp_valid = ctrl_q.resp_valid;
    assign bus_re     = ctrl_q.bus_re;
    assign bus_we     = ctrl_q.bus_we;

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master (TIMEOUT=8) with a small fixed-priority
// arbiter model used for the shared-bus scenario.
module tb_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_we;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        cmd_ready;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic        req;
    logic        gnt;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_re;
    logic        bus_we;
    logic [15:0] bus_rdata;
    logic        bus_ready;

    // Arbiter model: device 0 = DUT (high priority), device 1 = competitor.
    logic arb_en;
    logic gnt_drv;
    logic req1;
    logic gnt0_a;
    logic gnt1_a;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign gnt = arb_en ? gnt0_a : gnt_drv;

    // Owner keeps the bus while it requests; otherwise highest priority wins.
    always @(posedge clk) begin
        if (rst) begin
            gnt0_a <= 1'b0;
            gnt1_a <= 1'b0;
        end else if (gnt0_a && req) begin
            gnt0_a <= 1'b1;
            gnt1_a <= 1'b0;
        end else if (gnt1_a && req1) begin
            gnt0_a <= 1'b0;
            gnt1_a <= 1'b1;
        end else begin
            gnt0_a <= req;
            gnt1_a <= req1 && !req;
        end
    end

    bus_master #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_we     (cmd_we),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_ready  (cmd_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .req        (req),
        .gnt        (gnt),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_re     (bus_re),
        .bus_we     (bus_we),
        .bus_rdata  (bus_rdata),
        .bus_ready  (bus_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int ok;
        int accepts;
        int resps;
        int hold1;
        int raised;
        int gnt1_between;
        int req_low_done;

        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        bus_rdata = '0; bus_ready = 1'b0; gnt_drv = 1'b0; arb_en = 1'b0; req1 = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_cmd_ready",  {31'd0, cmd_ready}, 32'd1);
        chk("rst_req",        {31'd0, req}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_strobes",    {30'd0, bus_re, bus_we}, 32'd0);
        chk("rst_bus_addr",   {16'd0, bus_addr}, 32'd0);
        chk("rst_bus_wdata",  {16'd0, bus_wdata}, 32'd0);
        chk("rst_resp",       {15'd0, resp_err, resp_rdata}, 32'd0);
        rst = 1'b0;

        // Minimum-latency read
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 16'h0010;
        tick();                                   // REQ
        chk("rd_req_state", {30'd0, req, cmd_ready}, 32'b10);
        cmd_valid = 1'b0; cmd_addr = 16'hFFFF;    // must not disturb latched cmd
        gnt_drv = 1'b1; bus_ready = 1'b1; bus_rdata = 16'hBEEF;
        tick();                                   // XFER
        chk("rd_xfer_strobes", {30'd0, bus_re, bus_we}, 32'b10);
        chk("rd_xfer_addr",    {16'd0, bus_addr}, 32'h0010);
        chk("rd_xfer_wdata",   {16'd0, bus_wdata}, 32'h0000);
        tick();                                   // DONE: 4th cycle from accept
        chk("rd_done_ctrl",   {29'd0, resp_valid, req, cmd_ready}, 32'b100);
        chk("rd_resp_rdata",  {16'd0, resp_rdata}, 32'hBEEF);
        chk("rd_resp_err",    {31'd0, resp_err}, 32'd0);
        gnt_drv = 1'b0; bus_ready = 1'b0;
        tick();                                   // IDLE
        chk("rd_back_idle", {30'd0, resp_valid, cmd_ready}, 32'b01);

        // Write with bus_ready on the third XFER cycle
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 16'h0040; cmd_wdata = 16'h1234;
        tick();                                   // REQ
        cmd_valid = 1'b0; cmd_wdata = 16'hFFFF; cmd_addr = 16'h0000;
        gnt_drv = 1'b1;
        ok = 1;
        for (int i = 0; i < 3; i++) begin
            tick();                               // XFER cycle i+1
            if (!(bus_we === 1'b1 && bus_re === 1'b0 && bus_addr === 16'h0040 &&
                  bus_wdata === 16'h1234 && resp_valid === 1'b0)) ok = 0;
            if (i == 2) bus_ready = 1'b1;
        end
        chk("wr_xfer_stable_3cyc", ok, 1);
        tick();                                   // DONE
        chk("wr_done_ctrl",  {29'd0, resp_valid, bus_we, bus_re}, 32'b100);
        chk("wr_resp",       {15'd0, resp_err, resp_rdata}, 32'd0);
        chk("wr_bus_cleared", {bus_addr, bus_wdata}, 32'd0);
        gnt_drv = 1'b0; bus_ready = 1'b0;
        tick();

        // Grant withheld for 20 cycles: no timeout in REQ
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 16'h0123;
        tick();
        cmd_valid = 1'b0;
        ok = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!(req === 1'b1 && bus_re === 1'b0 && resp_valid === 1'b0)) ok = 0;
        end
        chk("gntwait_req_held", ok, 1);
        gnt_drv = 1'b1; bus_ready = 1'b1; bus_rdata = 16'h5A5A;
        tick();                                   // XFER
        chk("gntwait_xfer_addr", {15'd0, bus_re, bus_addr}, 32'h1_0123);
        tick();                                   // DONE
        chk("gntwait_resp", {14'd0, resp_valid, resp_err, resp_rdata}, 32'h2_5A5A);
        gnt_drv = 1'b0; bus_ready = 1'b0;
        tick();

        // Timeout: bus_ready never comes, TIMEOUT=8
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 16'h0200;
        tick();
        cmd_valid = 1'b0; gnt_drv = 1'b1; bus_rdata = 16'h1111;
        ok = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (!(bus_re === 1'b1 && resp_valid === 1'b0)) ok = 0;
        end
        chk("to_8_xfer_cycles", ok, 1);
        tick();                                   // DONE
        chk("to_resp", {14'd0, resp_valid, resp_err, resp_rdata}, 32'h3_0000);
        chk("to_strobe_off", {31'd0, bus_re}, 32'd0);
        gnt_drv = 1'b0;
        tick();
        chk("to_back_idle", {31'd0, cmd_ready}, 32'd1);

        // Grant lost in XFER: error even with bus_ready
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 16'h0300; cmd_wdata = 16'hAAAA;
        tick();
        cmd_valid = 1'b0; gnt_drv = 1'b1;
        tick();                                   // XFER
        gnt_drv = 1'b0; bus_ready = 1'b1; bus_rdata = 16'h7777;
        tick();                                   // DONE
        chk("gl_resp", {14'd0, resp_valid, resp_err, resp_rdata}, 32'h3_0000);
        bus_ready = 1'b0;
        tick();

        // Reset during XFER
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 16'h0400;
        tick();
        cmd_valid = 1'b0; gnt_drv = 1'b1;
        tick();                                   // XFER
        chk("rx_in_xfer", {31'd0, bus_re}, 32'd1);
        rst = 1'b1;
        tick();
        chk("rx_after_rst", {28'd0, req, bus_re, cmd_ready, resp_valid}, 32'b0010);
        rst = 1'b0; gnt_drv = 1'b0;
        tick();
        chk("rx_no_resp", {30'd0, resp_valid, req}, 32'd0);

        // Back-to-back commands through the arbiter with a competitor
        arb_en = 1'b1; bus_ready = 1'b1; bus_rdata = 16'h0F0F;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 16'h0500;
        accepts = 0; resps = 0; hold1 = 0; raised = 0; gnt1_between = 0; req_low_done = 1;
        for (int i = 0; i < 60 && resps < 2; i++) begin
            if (resp_valid) begin
                resps++;
                if (req !== 1'b0) req_low_done = 0;
            end
            if (resps == 1 && gnt1_a) gnt1_between = 1;
            if (gnt0_a && !raised) begin
                req1 = 1'b1;
                raised = 1;
            end
            if (gnt1_a) begin
                hold1++;
                if (hold1 == 2) req1 = 1'b0;
            end
            if (cmd_valid && cmd_ready) accepts++;
            tick();
            if (accepts >= 2) cmd_valid = 1'b0;
        end
        chk("arb_two_resps", resps, 2);
        chk("arb_req_low_in_done", req_low_done, 1);
        chk("arb_competitor_granted", gnt1_between, 1);
        chk("arb_last_rdata", {15'd0, resp_err, resp_rdata}, 32'h0_0F0F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
